// File: rtl/k_alu_pkg.sv
// Shared definitions for the K_ALU_32 sequencer: ALU op codes, FSM states, widths.
package k_alu_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SEL_W     = 4;
  localparam int unsigned MUL_ITERS = 32;

  localparam logic [SEL_W-1:0] ALU_ADD = 4'd0;
  localparam logic [SEL_W-1:0] ALU_SUB = 4'd1;
  localparam logic [SEL_W-1:0] ALU_LT  = 4'd2;
  localparam logic [SEL_W-1:0] ALU_GT  = 4'd3;
  localparam logic [SEL_W-1:0] ALU_AND = 4'd4;
  localparam logic [SEL_W-1:0] ALU_OR  = 4'd5;
  localparam logic [SEL_W-1:0] ALU_XOR = 4'd6;
  localparam logic [SEL_W-1:0] ALU_NOT = 4'd7;
  localparam logic [SEL_W-1:0] ALU_NOR = 4'd8;
  localparam logic [SEL_W-1:0] ALU_LUI = 4'd9;
  localparam logic [SEL_W-1:0] ALU_SLL = 4'd10;
  localparam logic [SEL_W-1:0] ALU_SRL = 4'd11;
  localparam logic [SEL_W-1:0] ALU_SRA = 4'd12;
  localparam logic [SEL_W-1:0] ALU_INC = 4'd13;
  localparam logic [SEL_W-1:0] ALU_DEC = 4'd14;
  localparam logic [SEL_W-1:0] ALU_HAM = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } seq_state_e;

  // Latched single-op payload
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_op_t;

endpackage

// File: rtl/k_alu_seq_if.sv
// Request/response handshake bundle between execute-stage control and the sequencer.
interface k_alu_seq_if;
  import k_alu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_mul;
  logic [SEL_W-1:0]  req_sel;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_mul, req_sel, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_mul, req_sel, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/k_alu_mul_iter.sv
// Shift-and-add multiply state: accumulator, shifting multiplicand/multiplier, iteration count.
module k_alu_mul_iter
  import k_alu_pkg::*;
#(
  parameter bit          EARLY_TERM = 1'b1,
  parameter int unsigned CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] mcand_init_i,
  input  logic [DATA_W-1:0] mplier_init_i,
  input  logic [DATA_W-1:0] add_res_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [DATA_W-1:0] mcand_o,
  output logic              done_c_o
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = mcand_init_i;
      mplier_d = mplier_init_i;
      cnt_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) acc_d = add_res_i;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Checked before iterating, so an all-zero multiplier never touches the ALU
  assign done_c_o = (EARLY_TERM && (mplier_q == '0)) || (cnt_q == CNT_W'(MUL_ITERS));
  assign acc_o    = acc_q;
  assign mcand_o  = mcand_q;

endmodule

// File: rtl/k_alu_seq.sv
// Sequencer driving an external K_ALU_32: single-cycle ops and iterative 32-bit multiply.
module k_alu_seq
  import k_alu_pkg::*;
#(
  parameter bit          EARLY_TERM = 1'b1,
  parameter int unsigned CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  k_alu_seq_if.slave        bus,
  output logic              busy,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_res
);

  seq_state_e        state_q, state_d;
  alu_op_t           op_q, op_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              ready_q, busy_q, rsp_valid_q;
  logic              mul_start, mul_step, mul_done;
  logic [DATA_W-1:0] mul_acc, mul_mcand;

  k_alu_mul_iter #(
    .EARLY_TERM (EARLY_TERM),
    .CNT_W      (CNT_W)
  ) u_mul_iter (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (mul_start),
    .step_i        (mul_step),
    .mcand_init_i  (bus.req_a),
    .mplier_init_i (bus.req_b),
    .add_res_i     (alu_res),
    .acc_o         (mul_acc),
    .mcand_o       (mul_mcand),
    .done_c_o      (mul_done)
  );

  // Next-state and ALU drive; ALU inputs are zero outside EXEC/MUL
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    mul_start  = 1'b0;
    mul_step   = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_sel    = ALU_ADD;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_mul) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else begin
            op_d    = '{sel: bus.req_sel, a: bus.req_a, b: bus.req_b};
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        alu_a      = op_q.a;
        alu_b      = op_q.b;
        alu_sel    = op_q.sel;
        rsp_data_d = alu_res;
        state_d    = RESP;
      end
      MUL: begin
        alu_a   = mul_acc;
        alu_b   = mul_mcand;
        alu_sel = ALU_ADD;
        if (mul_done) begin
          rsp_data_d = mul_acc;
          state_d    = RESP;
        end else begin
          mul_step = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
    endcase
  end

  // Handshake flags are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rsp_data_q  <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rsp_data_q  <= rsp_data_d;
      ready_q     <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      rsp_valid_q <= (state_d == RESP);
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_k_alu_seq.sv
// Randomized self-checking bench for k_alu_seq with both EARLY_TERM settings and a behavioural ALU.
module tb_k_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  k_alu_seq_if bus1 ();
  k_alu_seq_if bus0 ();

  logic        busy1, busy0;
  logic [31:0] alu_a1, alu_b1, alu_res1, alu_a0, alu_b0, alu_res0;
  logic [3:0]  alu_sel1, alu_sel0;

  // Shared request drive; cur selects which instance sees req_valid and is observed
  logic        cur = 1'b1;
  logic        rv = 1'b0, rm = 1'b0, rr = 1'b0;
  logic [3:0]  rs = '0;
  logic [31:0] ra = '0, rb = '0;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~a;
      4'd8:    return ~(a | b);
      4'd9:    return {b[15:0], 16'h0000};
      4'd10:   return a << b[4:0];
      4'd11:   return a >> b[4:0];
      4'd12:   return 32'($signed(a) >>> b[4:0]);
      4'd13:   return a + 32'd1;
      4'd14:   return a - 32'd1;
      default: return 32'($countones(a));
    endcase
  endfunction

  // Cycles spent iterating before the result is ready, from the multiply rules
  function automatic int mul_cycles(input bit et, input logic [31:0] b);
    if (!et) return 33;
    if (b == 32'd0) return 1;
    for (int i = 31; i >= 0; i--) if (b[i]) return i + 2;
    return 1;
  endfunction

  assign bus1.req_valid = rv & cur;
  assign bus0.req_valid = rv & ~cur;
  assign bus1.req_mul = rm;  assign bus0.req_mul = rm;
  assign bus1.req_sel = rs;  assign bus0.req_sel = rs;
  assign bus1.req_a = ra;    assign bus0.req_a = ra;
  assign bus1.req_b = rb;    assign bus0.req_b = rb;
  assign bus1.rsp_ready = rr; assign bus0.rsp_ready = rr;

  assign alu_res1 = alu_f(alu_sel1, alu_a1, alu_b1);
  assign alu_res0 = alu_f(alu_sel0, alu_a0, alu_b0);

  k_alu_seq #(.EARLY_TERM(1'b1), .CNT_W(6)) dut_et1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1), .alu_res(alu_res1)
  );

  k_alu_seq #(.EARLY_TERM(1'b0), .CNT_W(6)) dut_et0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_sel(alu_sel0), .alu_res(alu_res0)
  );

  logic        m_ready, m_valid, m_busy;
  logic [31:0] m_data, m_alu_a, m_alu_b;
  logic [3:0]  m_alu_sel;
  assign m_ready   = cur ? bus1.req_ready : bus0.req_ready;
  assign m_valid   = cur ? bus1.rsp_valid : bus0.rsp_valid;
  assign m_data    = cur ? bus1.rsp_data  : bus0.rsp_data;
  assign m_busy    = cur ? busy1 : busy0;
  assign m_alu_a   = cur ? alu_a1 : alu_a0;
  assign m_alu_b   = cur ? alu_b1 : alu_b0;
  assign m_alu_sel = cur ? alu_sel1 : alu_sel0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},   32'(m_ready),   32'd1);
    check({tag, "_valid"},   32'(m_valid),   32'd0);
    check({tag, "_busy"},    32'(m_busy),    32'd0);
    check({tag, "_alu_a"},   m_alu_a,        32'd0);
    check({tag, "_alu_b"},   m_alu_b,        32'd0);
    check({tag, "_alu_sel"}, 32'(m_alu_sel), 32'd0);
  endtask

  // One request through one instance, with `hold` cycles of response backpressure
  task automatic run_req(input bit et, input bit mul, input logic [3:0] sel,
                         input logic [31:0] a, input logic [31:0] b, input int hold,
                         output logic [31:0] got_d);
    logic [31:0] exp_d;
    int exp_n, n, w;
    exp_d = mul ? a * b : alu_f(sel, a, b);
    exp_n = mul ? mul_cycles(et, b) : 1;
    cur = et;
    @(negedge clk);
    rv = 1'b1; rm = mul; rs = sel; ra = a; rb = b; rr = 1'b0;
    w = 0;
    while (!m_ready && w < 50) begin @(negedge clk); w++; end
    check("accept_ready", 32'(m_ready), 32'd1);
    @(posedge clk); #1;
    rv = 1'b0; rm = 1'($urandom); rs = 4'($urandom); ra = $urandom; rb = $urandom;
    check("busy_after_accept", 32'(m_busy), 32'd1);
    check("ready_after_accept", 32'(m_ready), 32'd0);
    n = 0;
    while (!m_valid && n < 40) begin @(posedge clk); #1; n++; end
    check(mul ? "mul_cycles" : "exec_cycles", 32'(n), 32'(exp_n));
    check(mul ? "mul_data" : "op_data", m_data, exp_d);
    got_d = m_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", m_data, exp_d);
      check("hold_ready", 32'(m_ready), 32'd0);
      check("hold_alu_sel", 32'(m_alu_sel), 32'd0);
    end
    check("resp_alu_a", m_alu_a, 32'd0);
    rr = 1'b1;
    @(posedge clk); #1;
    rr = 1'b0;
    check("post_hs_valid", 32'(m_valid), 32'd0);
    check("post_hs_ready", 32'(m_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp_q [2];
    logic        acc;
    int          idx, got, saw;

    // Reset state of both instances
    repeat (3) @(negedge clk);
    cur = 1'b1; #1 check_idle_outputs("rst_et1"); check("rst_data_et1", m_data, 32'd0);
    cur = 1'b0; #1 check_idle_outputs("rst_et0"); check("rst_data_et0", m_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    cur = 1'b1; #1 check_idle_outputs("after_rst");

    // Directed single ops and multiplies
    run_req(1'b1, 1'b0, 4'd1, 32'd5, 32'd9, 0, d);              check("sub_lit", d, 32'hFFFF_FFFC);
    run_req(1'b1, 1'b0, 4'd4, 32'h0000_F0F0, 32'h0000_FF00, 1, d); check("and_lit", d, 32'h0000_F000);
    run_req(1'b1, 1'b1, 4'd9, 32'd7, 32'd6, 0, d);              check("mul42_et1", d, 32'd42);
    run_req(1'b0, 1'b1, 4'd0, 32'd7, 32'd6, 0, d);              check("mul42_et0", d, 32'd42);
    run_req(1'b1, 1'b1, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, d); check("mul_ones", d, 32'd1);
    run_req(1'b1, 1'b1, 4'd0, 32'h1234_5678, 32'd0, 0, d);      check("mul_zero", d, 32'd0);
    run_req(1'b0, 1'b1, 4'd0, 32'h1234_5678, 32'd0, 2, d);      check("mul_zero_et0", d, 32'd0);

    // Backpressure
    run_req(1'b1, 1'b0, 4'd6, 32'hDEAD_BEEF, 32'h1234_5678, 10, d);

    // Randomized mix over both instances and all op codes
    for (int k = 0; k < 24; k++) begin
      logic [31:0] ra_r, rb_r;
      bit          mul_r;
      ra_r  = $urandom;
      mul_r = 1'($urandom);
      rb_r  = mul_r ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      run_req(1'($urandom), mul_r, 4'($urandom), ra_r, rb_r, $urandom_range(0, 3), d);
    end

    // Back-to-back with req_valid held high
    cur = 1'b1; rr = 1'b1;
    exp_q[0] = 32'd7; exp_q[1] = 32'd12;
    @(negedge clk);
    rv = 1'b1; rm = 1'b0; rs = 4'd0; ra = 32'd3; rb = 32'd4;
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 100 && got < 2; cyc++) begin
      acc = m_ready && rv;
      if (m_valid) begin
        check($sformatf("b2b_rsp%0d", got), m_data, exp_q[got]);
        got++;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx == 1) begin rm = 1'b1; rs = 4'd5; ra = 32'd3; rb = 32'd4; end
        else rv = 1'b0;
      end
      @(negedge clk);
    end
    rv = 1'b0;
    check("b2b_count", 32'(got), 32'd2);
    check("b2b_accepts", 32'(idx), 32'd2);
    rr = 1'b0;
    @(negedge clk);

    // Reset in the middle of a long multiply
    cur = 1'b1;
    rv = 1'b1; rm = 1'b1; ra = 32'd3; rb = 32'hFFFF_FFFF;
    @(posedge clk); #1 rv = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1 check_idle_outputs("midrst");
    check("midrst_data", m_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    saw = 0;
    rr = 1'b1;
    repeat (40) begin @(negedge clk); if (m_valid || m_busy) saw++; end
    rr = 1'b0;
    check("midrst_no_rsp", 32'(saw), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
